// File: rtl/park_gate_sched.sv
// Barrier-gate scheduler: arbitrates two entry lanes and one exit lane over a
// single gate, sequences payment/open/clear on the Tick_1 timebase, tracks occupancy.
module park_gate_sched #(
   parameter int CAPACITY    = 9,
   parameter int GATE_TICKS  = 3,
   parameter int PAY_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Tick_1,
   input  logic       Ent_Sens_A,
   input  logic       Ent_Sens_B,
   input  logic       Exit_Sens,
   input  logic       paid_stat,
   output logic [2:0] Grant,
   output logic       Gate_Open,
   output logic       Green_State,
   output logic       Red_State,
   output logic [3:0] Sev_indicator,
   output logic       Full,
   output logic       Pay_Err
);

   localparam int MAX_TICKS = (GATE_TICKS > PAY_TIMEOUT) ? GATE_TICKS : PAY_TIMEOUT;
   localparam int TW        = $clog2(MAX_TICKS + 1);

   localparam logic [2:0]    G_A       = 3'b001;
   localparam logic [2:0]    G_B       = 3'b010;
   localparam logic [2:0]    G_EXIT    = 3'b100;
   localparam logic [3:0]    CAP       = 4'(CAPACITY);
   localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TICKS - 1);
   localparam logic [TW-1:0] PAY_LAST  = TW'(PAY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, PAY_WAIT, OPEN, CLEAR} state_t;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic          prefer_b;   // B wins the next A/B tie
   logic          exit_ok, a_ok, b_ok, lane_busy;
   logic [3:0]    done_count;

   always_comb begin
      exit_ok    = Exit_Sens && (Sev_indicator != 4'd0);
      a_ok       = Ent_Sens_A && (Sev_indicator < CAP);
      b_ok       = Ent_Sens_B && (Sev_indicator < CAP);
      lane_busy  = (Grant[0] && Ent_Sens_A) || (Grant[1] && Ent_Sens_B) ||
                   (Grant[2] && Exit_Sens);
      done_count = Sev_indicator;
      // Saturating update so the count can never wrap even if eligibility slipped.
      if (Grant[2]) begin
         if (Sev_indicator != 4'd0) done_count = Sev_indicator - 4'd1;
      end else if (Sev_indicator != CAP) begin
         done_count = Sev_indicator + 4'd1;
      end
   end

   // NOTE: all state and outputs use non-blocking assignments so every register
   // updates from the same pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         prefer_b      <= 1'b0;
         Grant         <= 3'b000;
         Gate_Open     <= 1'b0;
         Green_State   <= 1'b0;
         Red_State     <= 1'b1;
         Sev_indicator <= 4'd0;
         Full          <= 1'b0;
         Pay_Err       <= 1'b0;
      end else begin
         Pay_Err <= 1'b0;
         case (state)
            IDLE: begin
               tick_cnt <= '0;
               if (exit_ok) begin
                  Grant <= G_EXIT;
                  state <= PAY_WAIT;
               end else if (a_ok && (!b_ok || !prefer_b)) begin
                  Grant       <= G_A;
                  prefer_b    <= 1'b1;
                  state       <= OPEN;
                  Gate_Open   <= 1'b1;
                  Green_State <= 1'b1;
                  Red_State   <= 1'b0;
               end else if (b_ok) begin
                  Grant       <= G_B;
                  prefer_b    <= 1'b0;
                  state       <= OPEN;
                  Gate_Open   <= 1'b1;
                  Green_State <= 1'b1;
                  Red_State   <= 1'b0;
               end
            end

            PAY_WAIT: begin
               if (paid_stat) begin
                  state       <= OPEN;
                  tick_cnt    <= '0;
                  Gate_Open   <= 1'b1;
                  Green_State <= 1'b1;
                  Red_State   <= 1'b0;
               end else if (Tick_1) begin
                  if (tick_cnt == PAY_LAST) begin
                     Pay_Err  <= 1'b1;
                     state    <= CLEAR;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            OPEN: begin
               if (Tick_1) begin
                  if (tick_cnt == GATE_LAST) begin
                     Sev_indicator <= done_count;
                     Full          <= (done_count == CAP);
                     Gate_Open     <= 1'b0;
                     Green_State   <= 1'b0;
                     Red_State     <= 1'b1;
                     state         <= CLEAR;
                     tick_cnt      <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            CLEAR: begin
               // Hold the grant until the served car has left its sensor.
               if (!lane_busy) begin
                  Grant    <= 3'b000;
                  state    <= IDLE;
                  tick_cnt <= '0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/park_gate_sched.md
Name: park_gate_sched

Overview:
Controller that shares a single parking-lot barrier gate among two entry lanes (A, B) and one exit lane. It arbitrates lane requests, sequences each gate cycle (payment wait, open, clear), and maintains the occupancy count and full flag. It drives the red/green lamps and the 4-bit occupancy display value. Timing comes from the slow Tick_1 strobe rather than raw clock cycles.

Parameters:
CAPACITY, 9, maximum number of parked cars (1..15).
GATE_TICKS, 3, number of Tick_1 pulses the gate stays open.
PAY_TIMEOUT, 8, number of Tick_1 pulses to wait for paid_stat before aborting an exit.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
Tick_1  input  1  one-cycle timebase strobe.
Ent_Sens_A  input  1  car present at entry lane A (level).
Ent_Sens_B  input  1  car present at entry lane B (level).
Exit_Sens  input  1  car present at exit lane (level).
paid_stat  input  1  exit payment confirmed (level).
Grant  output  3  one-hot lane owner {exit, B, A}; 3'b000 when IDLE.
Gate_Open  output  1  barrier raise command.
Green_State  output  1  green lamp; high only in OPEN.
Red_State  output  1  always equals ~Green_State.
Sev_indicator  output  4  current occupancy count.
Full  output  1  high when Sev_indicator == CAPACITY.
Pay_Err  output  1  one-cycle pulse when an exit payment times out.

Behaviour:
- Reset (synchronous; takes priority in any state, including mid-cycle): state IDLE, Grant=0, Gate_Open=0, Green_State=0, Red_State=1, Sev_indicator=0, Full=0, Pay_Err=0, round-robin pointer set to A, tick counter cleared.
- All outputs are registered. States are IDLE, PAY_WAIT, OPEN, CLEAR.
- Eligibility:
  - An entry request is eligible only if occupancy < CAPACITY.
  - An exit request is eligible only if occupancy > 0.
  - Ineligible requests are ignored and are not queued.
- IDLE arbitration: an eligible exit has priority over entries. If only entries are eligible and both are, the lane not granted most recently wins (pointer starts at A). The pointer updates only when an entry grant is issued.
- IDLE transitions: a grant is registered on the same edge that samples the request, so Grant is visible one cycle later.
  - Exit grant goes to PAY_WAIT.
  - Entry grant goes to OPEN.
- Tick counter: cleared on every state entry. It counts Tick_1 pulses sampled while already in PAY_WAIT or OPEN, so a tick in the entry cycle itself is not counted.
- PAY_WAIT:
  - If paid_stat=1, go to OPEN next cycle.
  - Otherwise, when the PAY_TIMEOUT-th tick is sampled: Pay_Err pulses for 1 cycle, go to CLEAR, occupancy unchanged.
  - If paid_stat and the final tick arrive in the same cycle, paid_stat wins.
- OPEN: Gate_Open=1, Green_State=1. When the GATE_TICKS-th tick is sampled:
  - occupancy updates on that edge (+1 for an entry grant, -1 for an exit grant; exactly once per grant, never wrapping);
  - go to CLEAR.
- CLEAR: Gate_Open=0, Green_State=0, Grant held. Wait until the granted lane's sensor is 0, then go to IDLE with Grant=0. This prevents one car being counted twice.
- Sensor drop during PAY_WAIT or OPEN is ignored; the cycle completes.
- Full is combinationally consistent with the registered count, i.e. it updates on the same edge as Sev_indicator.
- Other lanes' requests during a gate cycle are held off and re-arbitrated in IDLE.

Test Plan:
1. Reset, raise Ent_Sens_A, issue 3 ticks, drop sensor -> Grant=001 one cycle later, Gate_Open high for exactly 3 ticks, Sev_indicator=1, Grant returns to 000, Red_State=1.
2. Ent_Sens_A and Ent_Sens_B held together for two full cycles -> first Grant=001, second Grant=010, Sev_indicator=2.
3. Occupancy 1, Exit_Sens and Ent_Sens_A asserted together -> Grant=100, PAY_WAIT; paid_stat=1 after 2 ticks -> OPEN, then Sev_indicator=0 after 3 ticks.
4. Occupancy 1, Exit_Sens with paid_stat=0 for 8 ticks -> Pay_Err 1-cycle pulse, Gate_Open never rises, Sev_indicator stays 1, IDLE only after Exit_Sens drops.
5. CAPACITY=2, fill to 2 -> Full=1; Ent_Sens_A held -> no grant; Exit_Sens plus payment -> Sev_indicator=1, Full=0, then entry A is granted.
6. Assert reset in OPEN with occupancy 3 -> next cycle IDLE, Gate_Open=0, Sev_indicator=0, Grant=000, pointer at A.
